// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive byte buffer presenting a first-word-fall-through
//               valid/ready stream, with fill level and drop accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clear,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [7:0]  c_drop_max = 8'hFF;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = rx_valid && (!w_full || w_pop);
    assign w_drop  = rx_valid && w_full && !w_pop;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clear) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != c_drop_max) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign m_valid  = !w_empty;
    assign m_data   = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clear;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    logic [7:0] sb[$];
    logic [7:0] b;

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        m_ready   = 1'b0;
        ovf_clear = 1'b0;
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single byte, one-cycle visibility, then pop.
        push(8'h41);
        check("t1_mvalid", m_valid, 1);
        check("t1_mdata", m_data, 8'h41);
        check("t1_count", count, 1);
        pop_one();
        check("t1_count_after", count, 0);
        check("t1_empty_after", empty, 1);

        // m_ready while empty changes nothing.
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("empty_ready_count", count, 0);

        // Fill then drain in order.
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_full", full, 1);
        check("t2_count", count, 16);
        check("t2_ovf", overflow, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_pop%0d", i), m_data, i);
            tick();
        end
        m_ready = 1'b0;
        check("t2_empty", empty, 1);

        // Overflow accounting.
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 3);
        check("t3_count", count, 16);
        check("t3_head", m_data, 8'h00);
        check("t3_stall_mvalid", m_valid, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t3_clr_ovf", overflow, 0);
        check("t3_clr_drop", drop_cnt, 0);

        // Clear coinciding with a drop: drop wins.
        rx_valid  = 1'b1;
        rx_data   = 8'hEE;
        ovf_clear = 1'b1;
        tick();
        rx_valid  = 1'b0;
        ovf_clear = 1'b0;
        check("clr_drop_ovf", overflow, 1);
        check("clr_drop_cnt", drop_cnt, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("clr2_ovf", overflow, 0);

        // Full with simultaneous push and pop.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        m_ready  = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("t4_count", count, 16);
        check("t4_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t4_pop%0d", i), m_data, i);
            tick();
        end
        check("t4_last", m_data, 8'h55);
        tick();
        m_ready = 1'b0;
        check("t4_empty", empty, 1);

        // Pointer wrap with scoreboard.
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            sb.push_back(b);
            push(b);
            check($sformatf("t5_pair%0d", i), m_data, sb.pop_front());
            pop_one();
        end
        check("t5_empty", empty, 1);

        // Saturation, then asynchronous reset between edges.
        for (int i = 0; i < 16; i++) push(8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        repeat (300) tick();
        rx_valid = 1'b0;
        check("t6_drop_sat", drop_cnt, 255);
        check("t6_ovf", overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_count", count, 0);
        check("t6_async_empty", empty, 1);
        check("t6_async_ovf", overflow, 0);
        check("t6_async_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push(8'h77);
        check("t6_post_data", m_data, 8'h77);
        check("t6_post_count", count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
